// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped, 16-line, write-through/no-write-allocate data cache controller.
// Stalls the pipeline (Dhit=0) while a read fill or a store write-through is in flight.
//
// state | meaning
// IDLE  | accept a new access; read hits complete combinationally
// RFILL | read miss outstanding to backing memory
// WTHRU | store being written through to backing memory
module dcache_stall_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        Dhit,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic [31:0] MissCount
);

    typedef enum logic [1:0] {IDLE, RFILL, WTHRU} state_t;

    state_t      state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] miss_q, miss_d;
    logic [15:0] valid_q, valid_d;
    logic [25:0] tag_q  [16];
    logic [31:0] line_q [16];

    logic        line_we;
    logic        tag_we;
    logic [31:0] line_wdata;
    logic [3:0]  req_idx;
    logic [3:0]  lat_idx;
    logic [25:0] lat_tag;
    logic        req_hit;
    logic        lat_hit;
    logic        unused_addr_bits;

    assign req_idx = AddrM[5:2];
    assign lat_idx = waddr_q[3:0];
    assign lat_tag = waddr_q[29:4];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == AddrM[31:6]);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    assign unused_addr_bits = ^AddrM[1:0];
    assign MissCount = miss_q;

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        miss_d     = miss_q;
        valid_d    = valid_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_wdata = MemRData;
        Dhit       = 1'b1;
        ReadDataM  = 32'h0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        MemAddr    = 32'h0;
        MemWData   = 32'h0;
        case (state_q)
            IDLE: begin
                // Store wins when both requests are raised together.
                if (MemWriteM) begin
                    Dhit    = 1'b0;
                    waddr_d = AddrM[31:2];
                    wdata_d = WriteDataM;
                    state_d = WTHRU;
                end else if (MemReadM) begin
                    if (req_hit) begin
                        ReadDataM = line_q[req_idx];
                    end else begin
                        Dhit    = 1'b0;
                        waddr_d = AddrM[31:2];
                        miss_d  = miss_q + 32'd1;
                        state_d = RFILL;
                    end
                end
            end
            RFILL: begin
                MemReq  = 1'b1;
                MemAddr = {waddr_q, 2'b00};
                Dhit    = MemAck;
                if (MemAck) begin
                    ReadDataM        = MemRData;
                    line_we          = 1'b1;
                    tag_we           = 1'b1;
                    valid_d[lat_idx] = 1'b1;
                    state_d          = IDLE;
                end
            end
            WTHRU: begin
                MemReq   = 1'b1;
                MemWe    = 1'b1;
                MemAddr  = {waddr_q, 2'b00};
                MemWData = wdata_q;
                Dhit     = MemAck;
                if (MemAck) begin
                    // No write-allocate: only refresh a line that already holds this word.
                    line_we    = lat_hit;
                    line_wdata = wdata_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            waddr_q <= 30'h0;
            wdata_q <= 32'h0;
            miss_q  <= 32'h0;
            valid_q <= 16'h0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Line data and tags carry no reset; they are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (line_we) line_q[lat_idx] <= line_wdata;
        if (tag_we)  tag_q[lat_idx]  <= lat_tag;
    end

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Randomised self-checking bench for dcache_stall_ctrl: a transaction-level model
// (backing memory as the truth for all loads, plus line residency) drives per-cycle expectations.
module tb_dcache_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] AddrM, WriteDataM, ReadDataM;
    logic        Dhit, MemReq, MemWe;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic        MemAck;
    logic [31:0] MissCount;

    always #5 clk = ~clk;

    dcache_stall_ctrl dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .Dhit(Dhit),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .MissCount(MissCount)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          chk_on = 1'b0;
    logic        exp_dhit, exp_req, exp_we, exp_chk_rd;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, exp_miss;

    logic [31:0] mem [bit [29:0]];
    bit          line_ok   [16];
    bit   [29:0] line_word [16];

    int          last_stall;
    logic [31:0] last_rdata, last_wdata_seen, last_addr_seen;
    logic        last_we_seen;

    function automatic logic [31:0] mem_val(input bit [29:0] w);
        if (mem.exists(w)) return mem[w];
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("Dhit", {31'h0, Dhit}, {31'h0, exp_dhit});
            chk("MemReq", {31'h0, MemReq}, {31'h0, exp_req});
            chk("MemWe", {31'h0, MemWe}, {31'h0, exp_we});
            if (exp_req) chk("MemAddr", MemAddr, exp_addr);
            if (exp_req && exp_we) chk("MemWData", MemWData, exp_wdata);
            if (exp_chk_rd) chk("ReadDataM", ReadDataM, exp_rdata);
            chk("MissCount", MissCount, exp_miss);
        end
    end

    // Called just after a rising edge with the controller idle; returns just after the
    // rising edge that completes the access.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
        bit [29:0] w;
        bit        is_st, is_ld, hit;
        logic      ack;
        w     = addr[31:2];
        is_st = wr;
        is_ld = rd && !wr;
        hit   = is_ld && line_ok[w[3:0]] && (line_word[w[3:0]] == w);
        MemReadM   = rd;
        MemWriteM  = wr;
        AddrM      = addr;
        WriteDataM = wd;
        MemAck     = 1'($urandom_range(0, 1));
        MemRData   = $urandom;
        last_stall = 0;
        last_we_seen = 1'b0;
        last_wdata_seen = 32'h0;
        last_addr_seen = 32'h0;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = 32'h0;
        exp_wdata = 32'h0;
        if (!is_st && !is_ld) begin
            exp_dhit = 1'b1; exp_chk_rd = 1'b1; exp_rdata = 32'h0;
        end else if (hit) begin
            exp_dhit = 1'b1; exp_chk_rd = 1'b1; exp_rdata = mem_val(w);
        end else begin
            exp_dhit = 1'b0; exp_chk_rd = 1'b0; exp_rdata = 32'h0;
        end
        @(negedge clk);
        last_rdata = ReadDataM;
        if (!Dhit) last_stall++;
        @(posedge clk); #1;
        if ((!is_st && !is_ld) || hit) return;
        if (is_ld) exp_miss = exp_miss + 32'd1;
        for (int k = 0; k <= lat; k++) begin
            ack        = (k == lat);
            AddrM      = $urandom;
            WriteDataM = $urandom;
            MemAck     = ack;
            MemRData   = (ack && is_ld) ? mem_val(w) : $urandom;
            exp_req    = 1'b1;
            exp_we     = is_st;
            exp_addr   = {w, 2'b00};
            exp_wdata  = wd;
            exp_dhit   = ack;
            exp_chk_rd = ack && is_ld;
            exp_rdata  = mem_val(w);
            @(negedge clk);
            if (!Dhit) last_stall++;
            last_rdata = ReadDataM;
            if (k == 0) begin
                last_we_seen    = MemWe;
                last_wdata_seen = MemWData;
                last_addr_seen  = MemAddr;
            end
            @(posedge clk); #1;
        end
        MemAck = 1'b0;
        if (is_ld) begin
            line_ok[w[3:0]]   = 1'b1;
            line_word[w[3:0]] = w;
        end else begin
            mem[w] = wd;
        end
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        bit          rd, wr;
        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; AddrM = 32'h0; WriteDataM = 32'h0;
        MemRData = 32'h0; MemAck = 1'b0;
        exp_miss = 32'h0;
        exp_dhit = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_chk_rd = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
        for (int i = 0; i < 16; i++) begin line_ok[i] = 1'b0; line_word[i] = 30'h0; end
        mem[30'h10] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_MemReq", {31'h0, MemReq}, 32'h0);
        chk("rst_MemWe", {31'h0, MemWe}, 32'h0);
        chk("rst_MissCount", MissCount, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_Dhit", {31'h0, Dhit}, 32'h1);
        @(posedge clk); #1;
        chk_on = 1'b1;

        do_op(1'b1, 1'b0, 32'h40, 32'h0, 3);
        chk("r40_stall", last_stall, 32'd4);
        chk("r40_data", last_rdata, 32'hDEAD_BEEF);
        chk("r40_memaddr", last_addr_seen, 32'h40);
        chk("r40_we", {31'h0, last_we_seen}, 32'h0);
        chk("r40_miss", MissCount, 32'd1);

        do_op(1'b1, 1'b0, 32'h40, 32'h0, 0);
        chk("rehit_stall", last_stall, 32'd0);
        chk("rehit_data", last_rdata, 32'hDEAD_BEEF);
        chk("rehit_miss", MissCount, 32'd1);

        do_op(1'b0, 1'b1, 32'h44, 32'h1234_5678, 2);
        chk("st44_we", {31'h0, last_we_seen}, 32'h1);
        chk("st44_wdata", last_wdata_seen, 32'h1234_5678);
        chk("st44_stall", last_stall, 32'd3);
        do_op(1'b1, 1'b0, 32'h44, 32'h0, 1);
        chk("r44_stall", last_stall, 32'd2);
        chk("r44_data", last_rdata, 32'h1234_5678);
        chk("r44_miss", MissCount, 32'd2);

        do_op(1'b0, 1'b1, 32'h40, 32'hCAFE_0000, 0);
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 2);
        chk("r40b_stall", last_stall, 32'd0);
        chk("r40b_data", last_rdata, 32'hCAFE_0000);
        do_op(1'b1, 1'b0, 32'h440, 32'h0, 1);
        chk("r440_stall", last_stall, 32'd2);
        chk("r440_miss", MissCount, 32'd3);
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 0);
        chk("r40c_stall", last_stall, 32'd1);
        chk("r40c_data", last_rdata, 32'hCAFE_0000);
        chk("r40c_miss", MissCount, 32'd4);

        do_op(1'b1, 1'b1, 32'h80, 32'h0BAD_F00D, 1);
        chk("both80_we", {31'h0, last_we_seen}, 32'h1);
        chk("both80_miss", MissCount, 32'd4);

        // Reset in the middle of a fill, then a stray ack.
        chk_on = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; AddrM = 32'h48; MemAck = 1'b0;
        @(posedge clk); #1;
        MemReadM = 1'b0;
        @(negedge clk);
        chk("mid_req_before", {31'h0, MemReq}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_req_drop", {31'h0, MemReq}, 32'h0);
        chk("mid_miss_clr", MissCount, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        MemAck = 1'b1; MemRData = 32'h1111_2222;
        @(negedge clk);
        chk("late_ack_req", {31'h0, MemReq}, 32'h0);
        chk("late_ack_dhit", {31'h0, Dhit}, 32'h1);
        @(posedge clk); #1;
        MemAck = 1'b0;
        for (int i = 0; i < 16; i++) line_ok[i] = 1'b0;
        exp_miss = 32'h0;
        chk_on = 1'b1;

        do_op(1'b1, 1'b0, 32'h40, 32'h0, 2);
        chk("post_rst_stall", last_stall, 32'd3);
        chk("post_rst_data", last_rdata, 32'hCAFE_0000);
        chk("post_rst_miss", MissCount, 32'd1);
        do_op(1'b1, 1'b0, 32'h48, 32'h0, 0);
        chk("r48_stall", last_stall, 32'd1);

        repeat (400) begin
            r  = $urandom_range(0, 9);
            a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'hF000_0000;
            rd = (r < 4) || (r == 9);
            wr = ((r >= 4) && (r < 7)) || (r == 9);
            do_op(rd, wr, a, $urandom, $urandom_range(0, 4));
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_stall_ctrl.md
DCACHE_STALL_CTRL -- requirements
Module: dcache_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port MemReadM, input, 1 bit: memory-stage load request.
REQ-004 SHALL have port MemWriteM, input, 1 bit: memory-stage store request.
REQ-005 SHALL have port AddrM, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-006 SHALL have port WriteDataM, input, 32 bits: store data.
REQ-007 SHALL have port ReadDataM, output, 32 bits: load data.
REQ-008 SHALL have port Dhit, output, 1 bit: 1 means the access completes this cycle or no access is pending; 0 stalls the pipeline registers.
REQ-009 SHALL have port MemReq, output, 1 bit: backing-memory request.
REQ-010 SHALL have port MemWe, output, 1 bit: backing-memory write enable.
REQ-011 SHALL have port MemAddr, output, 32 bits: word-aligned memory address.
REQ-012 SHALL have port MemWData, output, 32 bits: memory write data.
REQ-013 SHALL have port MemRData, input, 32 bits: memory read data, valid when MemAck=1.
REQ-014 SHALL have port MemAck, input, 1 bit: one-cycle completion pulse from memory.
REQ-015 SHALL have port MissCount, output, 32 bits: count of read misses.

Function
REQ-016 SHALL be direct-mapped with 16 one-word lines: index AddrM[5:2], tag AddrM[31:6], one valid bit per line.
REQ-017 SHALL use FSM states IDLE, RFILL and WTHRU.
REQ-018 SHALL, in IDLE with MemReadM=0 and MemWriteM=0, drive Dhit=1, MemReq=0 and ReadDataM=0.
REQ-019 SHALL, in IDLE on a read hit (valid and tag match), drive Dhit=1 and ReadDataM=line data combinationally in the same cycle, with zero stall cycles.
REQ-020 SHALL, in IDLE on a read miss, drive Dhit=0, latch the word address, go to RFILL, and increment MissCount by 1 (wrapping at 2^32).
REQ-021 SHALL, in RFILL, drive MemReq=1, MemWe=0, MemAddr={latched[31:2],2'b00} and Dhit=0 until MemAck=1.
REQ-022 SHALL, in RFILL on the MemAck=1 cycle: drive Dhit=1 and ReadDataM=MemRData (bypass); at that edge write the line data, set valid, write the tag, and return to IDLE.
REQ-023 SHALL, in IDLE with MemWriteM=1, drive Dhit=0, latch address and WriteDataM, and go to WTHRU (write-through on every store).
REQ-024 SHALL, in WTHRU, drive MemReq=1, MemWe=1, MemAddr=latched word address and MemWData=latched data until MemAck=1.
REQ-025 SHALL, in WTHRU on the MemAck=1 cycle, drive Dhit=1; at that edge update the line data only if the line is valid with a matching tag (no write-allocate), then return to IDLE.
REQ-026 SHALL give MemWriteM priority when MemReadM and MemWriteM are both 1; the access is treated as a store.
REQ-027 SHALL hold MemReq, MemWe, MemAddr and MemWData stable from request until ack, independent of AddrM and WriteDataM changes.
REQ-028 SHALL ignore MemAck while in IDLE.
REQ-029 SHALL require at least one cycle in RFILL/WTHRU, with MemReq first asserted the cycle after the miss or store is detected; MemAck may arrive on that first cycle.
REQ-030 SHALL, when the access following completion targets the just-filled line, report a hit with no further stall.

Reset
REQ-031 SHALL, on reset=1 and asynchronously, set state=IDLE, clear all valid bits, set MissCount=0 and drive MemReq=0 and MemWe=0.
REQ-032 SHALL leave line data and tags unreset (don't-care while invalid).
REQ-033 SHALL abandon any in-flight fill or write on reset mid-operation: MemReq drops immediately, no line is written, and a late MemAck is ignored.
REQ-034 SHALL, after reset with no access requested, drive Dhit=1.

Verification
REQ-035 Bench SHALL cover: reset, then read 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles -> Dhit=0 for 4 cycles, MemAddr=0x40 and MemWe=0 held, ack cycle Dhit=1 and ReadDataM=0xDEAD_BEEF, MissCount=1.
REQ-036 Bench SHALL cover: re-read 0x40 next cycle -> Dhit=1 same cycle, ReadDataM=0xDEAD_BEEF, MemReq=0, MissCount stays 1.
REQ-037 Bench SHALL cover: store 0x1234_5678 to 0x44 (invalid line), then read 0x44 -> store gives MemWe=1 and MemWData=0x1234_5678 until ack; the read misses, MissCount=2.
REQ-038 Bench SHALL cover: store 0xCAFE_0000 to 0x40 (hit), then read 0x40 -> hit with 0xCAFE_0000; read 0x440 (same index, different tag) -> miss, then read 0x40 -> miss.
REQ-039 Bench SHALL cover: MemReadM=MemWriteM=1 at 0x80 -> MemWe=1 and no MissCount increment.
REQ-040 Bench SHALL cover: reset asserted mid-RFILL, then MemAck pulse -> MemReq=0 immediately, read 0x40 misses again, MissCount=0 before the new miss.
